// File: rtl/seg7_scan_arbiter.sv
// Scan controller and two-client arbiter for an 8-digit common-anode seven-segment display.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zero digits of the owner's word).
//
// state | meaning
// IDLE  | no client owns the display, digit index parked at 0, pins dark
// OWN0  | client 0 owns the display, digits scanned from DATA0/DPIN0
// OWN1  | client 1 owns the display, digits scanned from DATA1/DPIN1
module seg7_scan_arbiter #(
    parameter int SCAN_DIV    = 100000,
    parameter int HOLD_FRAMES = 64
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic [1:0]  REQ,
    input  logic [31:0] DATA0,
    input  logic [31:0] DATA1,
    input  logic [7:0]  DPIN0,
    input  logic [7:0]  DPIN1,
    output logic [1:0]  GNT,
    output logic [7:0]  AN,
    output logic [0:6]  HEX0,
    output logic        DP
);

    localparam int              PRE_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [7:0]      HOLD_LIMIT = 8'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre;
    logic [2:0]       dig;
    logic [7:0]       hold;
    logic             last;

    logic tick;
    logic fb;
    logic own_idx;
    logic req_own;
    logic req_oth;

    assign tick    = (pre == PRE_LAST);
    assign fb      = tick && (dig == 3'd7);
    assign own_idx = (state == OWN1);
    assign req_own = REQ[own_idx];
    assign req_oth = REQ[~own_idx];

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state <= IDLE;
            GNT   <= 2'b00;
            pre   <= '0;
            dig   <= 3'd0;
            hold  <= 8'd0;
            last  <= 1'b1;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                case (state)
                    IDLE: begin
                        dig <= 3'd0;
                        // On a tie the client that did not own the display last wins.
                        if (REQ[0] && (!REQ[1] || last)) begin
                            state <= OWN0;
                            GNT   <= 2'b01;
                            hold  <= 8'd0;
                            last  <= 1'b0;
                        end else if (REQ[1]) begin
                            state <= OWN1;
                            GNT   <= 2'b10;
                            hold  <= 8'd0;
                            last  <= 1'b1;
                        end
                    end
                    OWN0, OWN1: begin
                        dig <= dig + 3'd1;
                        if (fb) begin
                            if ((!req_own && req_oth) ||
                                (req_own && req_oth && (hold >= HOLD_LIMIT))) begin
                                state <= own_idx ? OWN0 : OWN1;
                                GNT   <= own_idx ? 2'b01 : 2'b10;
                                hold  <= 8'd0;
                                last  <= ~own_idx;
                            end else if (!req_own) begin
                                state <= IDLE;
                                GNT   <= 2'b00;
                            end else if (hold != 8'hFF) begin
                                hold <= hold + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        GNT   <= 2'b00;
                        dig   <= 3'd0;
                    end
                endcase
            end
        end
    end

    function automatic logic [0:6] seg_decode(input logic [3:0] nib);
        logic [0:6] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    logic [31:0] sel_data;
    logic [7:0]  sel_dp;
    logic [3:0]  sel_nib;
    logic        blank;
    logic [7:0]  an_nxt;
    logic [0:6]  hex_nxt;
    logic        dp_nxt;

    assign sel_data = own_idx ? DATA1 : DATA0;
    assign sel_dp   = own_idx ? DPIN1 : DPIN0;
    assign sel_nib  = sel_data[{dig, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0] zero_from;

    // zero_from[k]: nibbles k..7 of the owner's word are all zero.
    always_comb begin
        zero_from    = 8'h00;
        zero_from[7] = (sel_data[31:28] == 4'h0);
        for (int k = 6; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (sel_data[4*k +: 4] == 4'h0);
        end
    end

    assign blank = (dig != 3'd0) && zero_from[dig] && !sel_dp[dig];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        an_nxt  = 8'hFF;
        hex_nxt = 7'b1111111;
        dp_nxt  = 1'b1;
        if ((state != IDLE) && !blank) begin
            an_nxt  = ~(8'h01 << dig);
            hex_nxt = seg_decode(sel_nib);
            dp_nxt  = ~sel_dp[dig];
        end
    end

    // Pins are registered so they lag dig and GNT by exactly one clock.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            AN   <= 8'hFF;
            HEX0 <= 7'b1111111;
            DP   <= 1'b1;
        end else begin
            AN   <= an_nxt;
            HEX0 <= hex_nxt;
            DP   <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_arbiter.sv
// Randomized self-checking bench for seg7_scan_arbiter against a cycle-level behavioural model.
module tb_seg7_scan_arbiter;

    localparam int SCAN_DIV    = 4;
    localparam int HOLD_FRAMES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] data0, data1;
    logic [7:0]  dpin0, dpin1;
    logic [1:0]  gnt;
    logic [7:0]  an;
    logic [0:6]  hex0;
    logic        dp;

    always #5 clk = ~clk;

    seg7_scan_arbiter #(
        .SCAN_DIV    (SCAN_DIV),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .CLK100MHZ (clk),
        .RST       (rst),
        .REQ       (req),
        .DATA0     (data0),
        .DATA1     (data1),
        .DPIN0     (dpin0),
        .DPIN1     (dpin1),
        .GNT       (gnt),
        .AN        (an),
        .HEX0      (hex0),
        .DP        (dp)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Model: owner is -1 when idle, cyc counts clocks within the current digit slot.
    int m_owner, m_slot, m_cyc, m_held, m_last;
    logic [1:0] exp_gnt;
    logic [7:0] exp_an;
    logic [6:0] exp_hex;
    logic       exp_dp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    task automatic model_grant(input int who);
        m_owner = who;
        m_last  = who;
        m_held  = 0;
    endtask

    task automatic model_update();
        logic [31:0] d;
        logic [7:0]  p;
        bit          lit;
        int          other;
        if (rst) begin
            m_owner = -1; m_slot = 0; m_cyc = 0; m_held = 0; m_last = 1;
            exp_an = 8'hFF; exp_hex = 7'h7F; exp_dp = 1'b1;
        end else begin
            exp_an = 8'hFF; exp_hex = 7'h7F; exp_dp = 1'b1;
            if (m_owner >= 0) begin
                d   = (m_owner == 1) ? data1 : data0;
                p   = (m_owner == 1) ? dpin1 : dpin0;
                lit = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (m_slot > 0 && (d >> (4 * m_slot)) == 32'd0 && !p[m_slot]) lit = 1'b0;
`endif
                if (lit) begin
                    exp_an  = ~(8'h01 << m_slot);
                    exp_hex = seg_tab[(d >> (4 * m_slot)) & 32'hF];
                    exp_dp  = ~p[m_slot];
                end
            end
            if (m_cyc == SCAN_DIV - 1) begin
                m_cyc = 0;
                if (m_owner < 0) begin
                    if (req == 2'b11)      model_grant(1 - m_last);
                    else if (req == 2'b01) model_grant(0);
                    else if (req == 2'b10) model_grant(1);
                end else begin
                    if (m_slot == 7) begin
                        other = 1 - m_owner;
                        if (!req[m_owner]) begin
                            if (req[other]) model_grant(other);
                            else m_owner = -1;
                        end else if (req[other] && m_held >= HOLD_FRAMES - 1) begin
                            model_grant(other);
                        end else if (m_held < 255) begin
                            m_held++;
                        end
                    end
                    m_slot = (m_slot + 1) % 8;
                end
            end else begin
                m_cyc++;
            end
        end
        exp_gnt = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("gnt", gnt, exp_gnt);
        chk("an", an, exp_an);
        chk("hex0", hex0, exp_hex);
        chk("dp", dp, exp_dp);
        chk("an_onehot", ($countones(~an) <= 1), 1);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        return w >> $urandom_range(0, 32);
    endfunction

    initial begin
        int waited;
        rst = 1'b1; req = 2'b00;
        data0 = '0; data1 = '0; dpin0 = '0; dpin1 = '0;
        repeat (2) step();
        rst = 1'b0;

        // Single requester: grant must arrive within one slot period.
        req = 2'b01; data0 = 32'h89AB_CDEF;
        waited = 0;
        while (gnt !== 2'b01 && waited <= SCAN_DIV) begin
            step();
            waited++;
        end
        chk("gnt_latency", gnt, 2'b01);
        repeat (8 * SCAN_DIV * 3 + 5) step();

        // Reset mid-grant.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Both request: alternation every HOLD_FRAMES frames.
        req = 2'b11; data1 = 32'h0123_4567; dpin1 = 8'h04; dpin0 = 8'h81;
        repeat (8 * SCAN_DIV * 8) step();

        // Owner drops mid-frame at digit 3.
        waited = 0;
        while ((m_owner < 0 || m_slot != 3) && waited < 8 * SCAN_DIV * 2) begin
            step();
            waited++;
        end
        chk("reach_dig3", (m_owner >= 0 && m_slot == 3), 1);
        req = (m_owner == 0) ? 2'b10 : 2'b01;
        repeat (8 * SCAN_DIV * 2) step();
        req = 2'b00;
        repeat (8 * SCAN_DIV * 2) step();
        chk("idle_after_drop", gnt, 2'b00);

        // Leading-zero words.
        req = 2'b01; data0 = 32'h0000_0012; dpin0 = 8'h00;
        repeat (8 * SCAN_DIV * 2 + 3) step();
        data0 = 32'h0000_0000;
        repeat (8 * SCAN_DIV * 2) step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 24) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) data0 = rand_word();
            if ($urandom_range(0, 3) == 0) data1 = rand_word();
            if ($urandom_range(0, 15) == 0) dpin0 = 8'($urandom());
            if ($urandom_range(0, 15) == 0) dpin1 = 8'($urandom());
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
